// File: rtl/cpld_image_arbiter.sv
// Two-client image arbiter for the CPLD display serializer.
// Grants one update at a time, commits it on a frame boundary (or after a timeout), then holds it for a few frames.
module cpld_image_arbiter #(
  parameter int C_HOLD_FRAMES    = 2,
  parameter int C_TIMEOUT_CYCLES = 1000000
) (
  input  logic        Bus2IP_Clk,
  input  logic        Bus2IP_Resetn,
  input  logic [1:0]  req,
  input  logic [23:0] data0,
  input  logic [23:0] data1,
  input  logic [2:0]  mask0,
  input  logic [2:0]  mask1,
  input  logic        prio_mode,
  input  logic        frame_start,
  input  logic        err_clr,
  output logic [1:0]  ack,
  output logic [23:0] img_out,
  output logic        commit,
  output logic        owner,
  output logic        busy,
  output logic        timeout_err
);

  localparam int TW = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] C_TLAST = TW'(C_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] C_TONE  = TW'(1);
  localparam logic [7:0]    C_HLAST = 8'(C_HOLD_FRAMES - 1);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_FRAME = 2'd1;
  localparam logic [1:0] S_HOLD       = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    r_ack;
  logic [23:0]   r_img;
  logic [23:0]   r_pend;
  logic          r_commit;
  logic          r_owner;
  logic          r_winner;
  logic          r_last;
  logic          r_terr;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    r_fcnt;

  logic          w_winner;
  logic [23:0]   w_data;
  logic [2:0]    w_mask;
  logic [23:0]   w_merged;
  logic          w_timeout;

  // A round-robin tie goes to the client that did not win last time.
  always_comb begin
    w_winner = 1'b0;
    case (req)
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = prio_mode ? 1'b0 : ~r_last;
      default: w_winner = 1'b0;
    endcase
  end

  assign w_data = w_winner ? data1 : data0;
  assign w_mask = w_winner ? mask1 : mask0;

  always_comb begin
    w_merged = r_img;
    if (w_mask[0]) w_merged[7:0]   = w_data[7:0];
    if (w_mask[1]) w_merged[15:8]  = w_data[15:8];
    if (w_mask[2]) w_merged[23:16] = w_data[23:16];
  end

  assign w_timeout = (r_tcnt == C_TLAST) && !frame_start;

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      r_state  <= S_IDLE;
      r_ack    <= 2'b00;
      r_img    <= 24'd0;
      r_pend   <= 24'd0;
      r_commit <= 1'b0;
      r_owner  <= 1'b0;
      r_winner <= 1'b0;
      r_last   <= 1'b1;
      r_terr   <= 1'b0;
      r_tcnt   <= '0;
      r_fcnt   <= 8'd0;
    end else begin
      r_ack    <= 2'b00;
      r_commit <= 1'b0;
      // A forced commit later in this block overrides a same-cycle clear.
      if (err_clr) r_terr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req != 2'b00) begin
            r_ack    <= w_winner ? 2'b10 : 2'b01;
            r_last   <= w_winner;
            r_winner <= w_winner;
            r_pend   <= w_merged;
            r_tcnt   <= '0;
            r_state  <= S_WAIT_FRAME;
          end
        end
        S_WAIT_FRAME: begin
          if (frame_start || w_timeout) begin
            r_img    <= r_pend;
            r_commit <= 1'b1;
            r_owner  <= r_winner;
            r_fcnt   <= 8'd0;
            r_state  <= S_HOLD;
            if (w_timeout) r_terr <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + C_TONE;
          end
        end
        S_HOLD: begin
          if (frame_start) begin
            if (r_fcnt == C_HLAST) begin
              r_fcnt  <= 8'd0;
              r_state <= S_IDLE;
            end else begin
              r_fcnt <= r_fcnt + 8'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack         = r_ack;
  assign img_out     = r_img;
  assign commit      = r_commit;
  assign owner       = r_owner;
  assign timeout_err = r_terr;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_cpld_image_arbiter.sv
// Scoreboard bench for cpld_image_arbiter: stimulus pushes expected acks/commits,
// a negedge monitor pops and compares them whenever the DUT pulses ack or commit.
module tb_cpld_image_arbiter;

  localparam int HOLD = 2;
  localparam int TMO  = 20;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [23:0] data0 = 24'd0;
  logic [23:0] data1 = 24'd0;
  logic [2:0]  mask0 = 3'd0;
  logic [2:0]  mask1 = 3'd0;
  logic        prioMode = 1'b0;
  logic        frameStart = 1'b0;
  logic        errClr = 1'b0;
  logic [1:0]  ack;
  logic [23:0] imgOut;
  logic        commit;
  logic        owner;
  logic        busy;
  logic        timeoutErr;

  cpld_image_arbiter #(.C_HOLD_FRAMES(HOLD), .C_TIMEOUT_CYCLES(TMO)) dut (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(rstN), .req(req),
    .data0(data0), .data1(data1), .mask0(mask0), .mask1(mask1),
    .prio_mode(prioMode), .frame_start(frameStart), .err_clr(errClr),
    .ack(ack), .img_out(imgOut), .commit(commit), .owner(owner),
    .busy(busy), .timeout_err(timeoutErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          isCommit;
    logic [1:0]  ack;
    logic [23:0] img;
    logic        owner;
    logic        terr;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int failures = 0;

  // Reference model: committed image, pending image, last winner, sticky error.
  logic [23:0] mImg = 24'd0;
  logic [23:0] mPend = 24'd0;
  logic        mLast = 1'b1;
  logic        mWin = 1'b0;
  logic        mErr = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, want);
    end
  endtask

  function automatic logic [23:0] mergeImg(input logic [23:0] base, input logic [23:0] d, input logic [2:0] m);
    logic [23:0] r;
    r = base;
    for (int b = 0; b < 3; b++)
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack or commit pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rstN) begin
      if (ack !== 2'b00) begin
        if (expQ.size() == 0 || expQ[0].isCommit) checkOutput("unexpected_ack", {30'd0, ack}, 32'd0);
        else begin
          e = expQ.pop_front();
          checkOutput("ack", {30'd0, ack}, {30'd0, e.ack});
        end
      end
      if (commit !== 1'b0) begin
        if (expQ.size() == 0 || !expQ[0].isCommit) checkOutput("unexpected_commit", {31'd0, commit}, 32'd0);
        else begin
          e = expQ.pop_front();
          checkOutput("commit_img", {8'd0, imgOut}, {8'd0, e.img});
          checkOutput("commit_owner", {31'd0, owner}, {31'd0, e.owner});
          checkOutput("commit_terr", {31'd0, timeoutErr}, {31'd0, e.terr});
        end
      end
    end
  end

  task automatic doReset();
    rstN = 1'b0;
    req = 2'b00; frameStart = 1'b0; errClr = 1'b0;
    #2;
    checkOutput("rst_img", {8'd0, imgOut}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ack", {30'd0, ack}, 32'd0);
    checkOutput("rst_commit", {31'd0, commit}, 32'd0);
    checkOutput("rst_owner", {31'd0, owner}, 32'd0);
    checkOutput("rst_terr", {31'd0, timeoutErr}, 32'd0);
    expQ.delete();
    mImg = 24'd0; mPend = 24'd0; mLast = 1'b1; mWin = 1'b0; mErr = 1'b0;
    step();
    step();
    rstN = 1'b1;
  endtask

  // Predicts the winner for the request currently on the inputs and queues its ack.
  task automatic predictGrant(input logic [1:0] reqV);
    exp_t e;
    logic w;
    if (reqV == 2'b10) w = 1'b1;
    else if (reqV == 2'b01) w = 1'b0;
    else w = prioMode ? 1'b0 : ~mLast;
    e = '{isCommit: 1'b0, ack: (w ? 2'b10 : 2'b01), img: 24'd0, owner: 1'b0, terr: 1'b0};
    expQ.push_back(e);
    mLast = w;
    mWin = w;
    mPend = mergeImg(mImg, w ? data1 : data0, w ? mask1 : mask0);
  endtask

  task automatic applyStimulus(input logic [1:0] reqV, input logic [23:0] d0, input logic [2:0] m0,
                               input logic [23:0] d1, input logic [2:0] m1);
    data0 = d0; mask0 = m0; data1 = d1; mask1 = m1; req = reqV;
    predictGrant(reqV);
    step();
    req = 2'b00;
    checkOutput("busy_after_ack", {31'd0, busy}, 32'd1);
  endtask

  task automatic commitOnFrame();
    exp_t e;
    e = '{isCommit: 1'b1, ack: 2'b00, img: mPend, owner: mWin, terr: mErr};
    expQ.push_back(e);
    mImg = mPend;
    frameStart = 1'b1;
    step();
    frameStart = 1'b0;
    checkOutput("busy_in_hold", {31'd0, busy}, 32'd1);
  endtask

  // Called right after the ack edge; the forced commit lands TMO edges later.
  task automatic commitOnTimeout(input logic clr);
    exp_t e;
    repeat (TMO - 1) step();
    e = '{isCommit: 1'b1, ack: 2'b00, img: mPend, owner: mWin, terr: 1'b1};
    expQ.push_back(e);
    mImg = mPend;
    mErr = 1'b1;
    errClr = clr;
    step();
    errClr = 1'b0;
    checkOutput("terr_after_timeout", {31'd0, timeoutErr}, 32'd1);
  endtask

  task automatic finishHold(input int gapMax);
    for (int i = 0; i < HOLD; i++) begin
      repeat ($urandom_range(0, gapMax)) step();
      if (i == HOLD - 1) checkOutput("busy_before_last_frame", {31'd0, busy}, 32'd1);
      frameStart = 1'b1;
      step();
      frameStart = 1'b0;
    end
    checkOutput("idle_after_hold", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] rd0, rd1;
    logic [1:0]  rq;
    step();
    doReset();

    // Basic grant and commit
    applyStimulus(2'b01, 24'h123456, 3'b111, 24'h0, 3'b000);
    commitOnFrame();
    checkOutput("img_first", {8'd0, imgOut}, 32'h123456);
    finishHold(0);

    // Partial mask from client 1
    applyStimulus(2'b10, 24'h0, 3'b000, 24'hAABBCC, 3'b010);
    commitOnFrame();
    checkOutput("img_masked", {8'd0, imgOut}, 32'h12BB56);
    finishHold(2);

    // Empty mask still commits an unchanged image
    applyStimulus(2'b01, 24'hFFFFFF, 3'b000, 24'h0, 3'b000);
    commitOnFrame();
    checkOutput("img_mask0", {8'd0, imgOut}, 32'h12BB56);
    finishHold(1);

    // Round-robin then fixed priority on a tie
    doReset();
    prioMode = 1'b0;
    repeat (3) begin
      applyStimulus(2'b11, 24'h111111, 3'b111, 24'h222222, 3'b111);
      commitOnFrame();
      finishHold(0);
    end
    prioMode = 1'b1;
    repeat (3) begin
      applyStimulus(2'b11, 24'h333333, 3'b001, 24'h444444, 3'b100);
      commitOnFrame();
      finishHold(0);
    end
    prioMode = 1'b0;

    // Timeout, clear, then clear coinciding with a second timeout
    applyStimulus(2'b10, 24'h0, 3'b000, 24'h5A5A5A, 3'b101);
    commitOnTimeout(1'b0);
    errClr = 1'b1;
    step();
    errClr = 1'b0;
    mErr = 1'b0;
    checkOutput("terr_cleared", {31'd0, timeoutErr}, 32'd0);
    finishHold(0);
    applyStimulus(2'b01, 24'hC3C3C3, 3'b011, 24'h0, 3'b000);
    commitOnTimeout(1'b1);
    finishHold(0);

    // Reset in the middle of WAIT_FRAME discards the pending image
    applyStimulus(2'b01, 24'h987654, 3'b111, 24'h0, 3'b000);
    repeat (5) step();
    doReset();
    frameStart = 1'b1;
    step();
    frameStart = 1'b0;
    checkOutput("no_commit_after_reset", {31'd0, commit}, 32'd0);
    checkOutput("img_after_reset", {8'd0, imgOut}, 32'd0);

    // Request raised during HOLD waits for IDLE
    applyStimulus(2'b10, 24'h0, 3'b000, 24'h0F0F0F, 3'b111);
    commitOnFrame();
    data0 = 24'hABCDEF; mask0 = 3'b110; req = 2'b01;
    frameStart = 1'b1;
    step();
    frameStart = 1'b0;
    checkOutput("hold_no_ack1", {30'd0, ack}, 32'd0);
    step();
    checkOutput("hold_no_ack2", {30'd0, ack}, 32'd0);
    frameStart = 1'b1;
    step();
    frameStart = 1'b0;
    checkOutput("hold_no_ack3", {30'd0, ack}, 32'd0);
    checkOutput("hold_exit_idle", {31'd0, busy}, 32'd0);
    predictGrant(2'b01);
    step();
    req = 2'b00;
    checkOutput("busy_late_grant", {31'd0, busy}, 32'd1);
    commitOnFrame();
    finishHold(1);
    frameStart = 1'b1;
    step();
    frameStart = 1'b0;
    checkOutput("idle_frame_no_commit", {31'd0, commit}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      rd0 = 24'($urandom());
      rd1 = 24'($urandom());
      rq = 2'($urandom_range(1, 3));
      prioMode = 1'($urandom_range(0, 1));
      applyStimulus(rq, rd0, 3'($urandom()), rd1, 3'($urandom()));
      if ($urandom_range(0, 5) == 0) begin
        commitOnTimeout(1'($urandom_range(0, 1)));
      end else begin
        repeat ($urandom_range(0, TMO - 3)) step();
        commitOnFrame();
      end
      finishHold(3);
    end

    step();
    checkOutput("scoreboard_drain", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpld_image_arbiter.md
CPLD_IMAGE_ARBITER -- requirements
Module: cpld_image_arbiter

Interface
REQ-001 SHALL have parameter C_HOLD_FRAMES, default 2, minimum frames an image stays committed before the next grant (range 1..255).
REQ-002 SHALL have parameter C_TIMEOUT_CYCLES, default 1000000, maximum clocks to wait for a frame boundary before a forced commit (range ≥2).
REQ-003 SHALL have port Bus2IP_Clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port Bus2IP_Resetn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, 2, per-client update request (client 0 = bus/software, client 1 = hardware game engine).
REQ-006 SHALL have ports data0 and data1, input, 24 each, client image {disp2[23:16], disp1[15:8], led[7:0]}.
REQ-007 SHALL have ports mask0 and mask1, input, 3 each, byte enables {disp2, disp1, led}.
REQ-008 SHALL have port prio_mode, input, 1, arbitration policy: 0 = round-robin, 1 = fixed priority to client 0.
REQ-009 SHALL have port frame_start, input, 1, one-clock pulse from the CPLD serializer at its shift-register load.
REQ-010 SHALL have port err_clr, input, 1, clears the sticky timeout flag.
REQ-011 SHALL have port ack, output, 2, one-clock grant acknowledge per client.
REQ-012 SHALL have port img_out, output, 24, committed image to the serializer.
REQ-013 SHALL have port commit, output, 1, one-clock pulse when img_out changes.
REQ-014 SHALL have port owner, output, 1, client whose request was committed last.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-016 SHALL have port timeout_err, output, 1, sticky flag for a forced commit.

Function
REQ-017 SHALL implement the states IDLE, WAIT_FRAME and HOLD.
REQ-018 In IDLE with req != 0, the block SHALL choose a winner and, on the same edge, pulse ack[winner] for one cycle. It SHALL load pending = img_out with the masked bytes of the winner's data replaced, record the winner, and go to WAIT_FRAME.
REQ-019 Round-robin arbitration SHALL give a single requester the grant, and SHALL give a tie to the client that is not last_grant. Fixed-priority arbitration SHALL give a tie to client 0.
REQ-020 last_grant SHALL update only on an ack.
REQ-021 ack SHALL never be asserted outside IDLE, and never to a client whose req is low.
REQ-022 A request that is held SHALL be re-arbitrated only after the block returns to IDLE. Clients drop req after ack.
REQ-023 In WAIT_FRAME, frame_start SHALL cause img_out = pending, commit = 1 for one cycle, owner = winner, frame counter = 0, and a move to HOLD on the same edge.
REQ-024 The WAIT_FRAME cycle counter SHALL start at 0 on entry and increment each cycle without frame_start.
REQ-025 When the WAIT_FRAME counter reaches C_TIMEOUT_CYCLES-1 without frame_start, the block SHALL commit as in REQ-023, set timeout_err, and go to HOLD.
REQ-026 In HOLD, each frame_start SHALL increment the frame counter. When the counter reaches C_HOLD_FRAMES, the block SHALL go to IDLE on that edge.
REQ-027 In HOLD, requests SHALL be ignored (no ack).
REQ-028 frame_start in IDLE SHALL be ignored.
REQ-029 Counter widths SHALL be ceil(log2(C_TIMEOUT_CYCLES)) for the timeout counter and 8 for the frame counter. Counters SHALL not wrap in normal operation.
REQ-030 timeout_err SHALL set on a forced commit and clear on err_clr. Simultaneous set and clear SHALL leave the flag set.
REQ-031 A mask of 3'b000 SHALL still be granted and committed (img_out unchanged, commit pulses).
REQ-032 busy SHALL be combinational from the state. All other outputs SHALL be registered.

Reset
REQ-033 Asserting Bus2IP_Resetn low at any time, including mid-WAIT_FRAME or mid-HOLD, SHALL immediately set: state = IDLE, img_out = 0, pending = 0, ack = 0, commit = 0, owner = 0, timeout_err = 0, counters = 0, last_grant = 1 (client 0 wins the first round-robin tie).
REQ-034 A pending uncommitted image SHALL be discarded by reset.
REQ-035 After reset deassertion, the first arbitration SHALL be possible on the first rising edge.

Verification
REQ-036 Scenario (C_HOLD_FRAMES = 2, C_TIMEOUT_CYCLES = 20 for all): reset; req = 01, data0 = 0x123456, mask0 = 111 -> ack = 01 next edge. Then frame_start -> img_out = 0x123456, commit pulse, owner = 0. Then busy stays high until the 2nd frame_start.
REQ-037 Scenario: img_out = 0x123456; req = 10, data1 = 0xAABBCC, mask1 = 010 -> img_out = 0x12BB56 after frame_start.
REQ-038 Scenario: round-robin; req = 11 held through three arbitrations -> acks alternate 01, 10, 01. With prio_mode = 1 -> acks are 01, 01, 01.
REQ-039 Scenario: grant with no frame_start -> forced commit 20 cycles after WAIT_FRAME entry, timeout_err = 1. Then err_clr -> 0. Then err_clr together with another timeout -> timeout_err stays 1.
REQ-040 Scenario: reset asserted 5 cycles into WAIT_FRAME -> img_out = 0, busy = 0, and no commit on a subsequent frame_start.
REQ-041 Scenario: req raised during HOLD -> no ack until the 2nd frame_start, ack on the first edge in IDLE. frame_start while idle -> no commit.
